// File: rtl/uart_autobaud.sv
// uart_autobaud: times a 0x55 sync character on rx and derives the matching UBRR divisor.
// The interval from the 1st to the 5th falling edge is 8 bit periods, so
// UBRR = floor(8 * CPU_freq / count).
module uart_autobaud #(
    parameter int unsigned CPU_freq   = 'd100000000,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned DIV_W      = 36,
    parameter logic [11:0] UBRR_RESET = 12'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        start,
    output logic [11:0] UBRR,
    output logic        ubrr_valid,
    output logic        err,
    output logic        busy
);

    localparam int unsigned UBRR_W = 12;
    localparam int unsigned EDGE_W = 3;
    localparam int unsigned DC_W   = $clog2(DIV_W + 1);

    localparam logic [63:0]       DIVIDEND_64 = 64'(CPU_freq) * 64'd8;
    localparam logic [DIV_W-1:0]  DIVIDEND    = DIV_W'(DIVIDEND_64);
    // Value of the counter in the cycle before it reaches 2^CNT_W-1.
    localparam logic [CNT_W-1:0]  CNT_TMO     = ~CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        MEASURE,
        DIVIDE,
        DONE
    } state_t;

    state_t              state;
    logic                rx_meta;
    logic                rx_sync;
    logic                rx_prev;
    logic                fall;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    meas;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [DC_W-1:0]     div_cnt;
    logic [DIV_W-1:0]    dvd;
    logic [DIV_W-1:0]    quo;
    logic [CNT_W-1:0]    rem;
    logic [CNT_W:0]      rem_s;
    logic [CNT_W-1:0]    diff;
    logic                ge;

    // One restoring-divider step: shift in the next dividend bit and trial-subtract.
    assign rem_s = {rem, dvd[DIV_W-1]};
    assign ge    = (rem_s >= {1'b0, meas});
    assign diff  = rem_s[CNT_W-1:0] - meas;
    assign fall  = rx_prev & ~rx_sync;

    // Two-flop synchronizer plus previous-sample register for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Control FSM: arm, measure 8 bit periods, divide, publish the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            UBRR       <= UBRR_RESET;
            ubrr_valid <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            meas       <= '0;
            edge_cnt   <= '0;
            div_cnt    <= '0;
            dvd        <= '0;
            quo        <= '0;
            rem        <= '0;
        end else begin
            ubrr_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (fall) begin
                        cnt      <= '0;
                        edge_cnt <= EDGE_W'(1);
                        state    <= MEASURE;
                    end
                end
                MEASURE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (fall && edge_cnt == EDGE_W'(4)) begin
                        // cnt trails the cycle count by one; latch the full interval.
                        meas     <= cnt + CNT_W'(1);
                        edge_cnt <= EDGE_W'(5);
                        div_cnt  <= '0;
                        state    <= DIVIDE;
                    end else begin
                        if (fall) begin
                            edge_cnt <= edge_cnt + EDGE_W'(1);
                        end
                        if (cnt == CNT_TMO) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                DIVIDE: begin
                    if (div_cnt == '0) begin
                        // First cycle screens out too-short intervals and loads the divider.
                        if (meas < CNT_W'(8)) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            dvd     <= DIVIDEND;
                            rem     <= '0;
                            quo     <= '0;
                            div_cnt <= DC_W'(1);
                        end
                    end else begin
                        dvd     <= dvd << 1;
                        rem     <= ge ? diff : rem_s[CNT_W-1:0];
                        quo     <= {quo[DIV_W-2:0], ge};
                        div_cnt <= div_cnt + DC_W'(1);
                        if (div_cnt == DC_W'(DIV_W)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Only a quotient that fits 1..4095 may reach the generator.
                    if (quo != '0 && quo[DIV_W-1:UBRR_W] == '0) begin
                        UBRR       <= quo[UBRR_W-1:0];
                        ubrr_valid <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: drives 0x55 frames at chosen bit periods and checks every
// cycle against an event-schedule model computed from edge timing arithmetic.
module tb_uart_autobaud;

    localparam int CPU_FREQ = 1000000;
    localparam int CNT_W    = 14;
    localparam int DIV_W    = 24;
    localparam int TMO      = (1 << CNT_W) - 1;
    localparam int UBRR_RST = 77;
    localparam int INF      = 32'h7FFF_FFFF;
    localparam int RES_LAT  = 3 + DIV_W + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        start;
    logic [11:0] UBRR;
    logic        ubrr_valid;
    logic        err;
    logic        busy;

    uart_autobaud #(
        .CPU_freq  (CPU_FREQ),
        .CNT_W     (CNT_W),
        .DIV_W     (DIV_W),
        .UBRR_RESET(12'd77)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .start     (start),
        .UBRR      (UBRR),
        .ubrr_valid(ubrr_valid),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int   cyc   = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Model schedule: busy window, result cycle and result content.
    int busy_from = INF;
    int res_cyc   = INF;
    bit res_ok    = 1'b0;
    int res_q     = 0;
    int ubrr_model = UBRR_RST;
    bit chk_en    = 1'b0;
    bit done      = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int n_valid = 0;
    int n_err   = 0;
    int last_valid_cyc = 0;
    int last_err_cyc   = 0;
    int last_k5 = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic arm();
        @(posedge clk); #1;
        start = 1'b1;
        busy_from = cyc + 1;
        res_cyc = INF;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic poke_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        busy_from = INF;
        res_cyc = INF;
    endtask

    // Send the first nbits of a 0x55 8N1 frame with bit period p.
    task automatic send_frame(input int p, input int nbits, input bit poke);
        bit [9:0] lv;
        int nf;
        int k1;
        int cnt;
        longint q;
        lv = 10'b1010101010;
        nf = 0;
        k1 = 0;
        for (int i = 0; i < nbits; i++) begin
            rx = lv[i];
            if (!lv[i]) begin
                nf++;
                if (nf == 1) k1 = cyc;
                if (nf == 5) begin
                    last_k5 = cyc;
                    cnt = cyc - k1;
                    q = (longint'(CPU_FREQ) * 8) / longint'(cnt);
                    res_ok = (cnt >= 8) && (q >= 1) && (q <= 4095);
                    res_q = int'(q);
                    res_cyc = cyc + RES_LAT;
                end
            end
            if (poke && i == 8) begin
                repeat (10) @(posedge clk);
                #1; start = 1'b1;
                @(posedge clk);
                #1; start = 1'b0;
                repeat (p - 11) @(posedge clk);
                #1;
            end else begin
                repeat (p) @(posedge clk);
                #1;
            end
        end
        rx = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        start = 1'b0;
        fork
            begin : compare
                while (!done) begin
                    @(negedge clk);
                    if (rst_q) begin
                        ubrr_model = UBRR_RST;
                        chk_en = 1'b1;
                    end
                    if (chk_en) begin
                        if (!rst_q && cyc == res_cyc && res_ok) ubrr_model = res_q;
                        check("busy", int'(busy), int'(!rst_q && cyc >= busy_from && cyc < res_cyc));
                        check("ubrr_valid", int'(ubrr_valid), int'(!rst_q && cyc == res_cyc && res_ok));
                        check("err", int'(err), int'(!rst_q && cyc == res_cyc && !res_ok));
                        check("UBRR", int'(UBRR), ubrr_model);
                    end
                    if (ubrr_valid) begin
                        n_valid++;
                        last_valid_cyc = cyc;
                    end
                    if (err) begin
                        n_err++;
                        last_err_cyc = cyc;
                    end
                end
            end
            begin : stim
                int k1;
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                check("reset_ubrr", int'(UBRR), 77);
                check("reset_busy", int'(busy), 0);
                check("reset_valid", int'(ubrr_valid), 0);
                check("reset_err", int'(err), 0);

                // 16000-cycle interval -> 500, result DIV_W+2 after the 5th edge is acted on
                arm();
                send_frame(2000, 10, 1'b0);
                check("ubrr_p2000", int'(UBRR), 500);
                check("latency_p2000", last_valid_cyc - last_k5, 29);
                check("busy_after_p2000", int'(busy), 0);

                arm();
                send_frame(250, 10, 1'b0);
                check("ubrr_p250", int'(UBRR), 4000);

                arm();
                send_frame(1000, 10, 1'b0);
                check("ubrr_p1000", int'(UBRR), 1000);

                // q = 5000 does not fit 12 bits
                arm();
                send_frame(200, 10, 1'b0);
                check("ubrr_p200_kept", int'(UBRR), 1000);

                // 4098 just above, 4081 just below the 4095 ceiling
                arm();
                send_frame(244, 10, 1'b0);
                check("ubrr_p244_kept", int'(UBRR), 1000);
                arm();
                send_frame(245, 10, 1'b0);
                check("ubrr_p245", int'(UBRR), 4081);

                // start while busy in WAIT_START and in DIVIDE is ignored
                arm();
                repeat (3) @(posedge clk);
                #1;
                poke_start();
                send_frame(300, 10, 1'b1);
                check("ubrr_p300", int'(UBRR), 3333);

                // rx activity while idle changes nothing
                repeat (3) begin
                    rx = 1'b0;
                    repeat (20) @(posedge clk);
                    #1;
                    rx = 1'b1;
                    repeat (20) @(posedge clk);
                    #1;
                end
                repeat (10) @(posedge clk);
                #1;
                check("idle_ubrr", int'(UBRR), 3333);
                check("idle_busy", int'(busy), 0);

                // rx stuck low: timeout
                arm();
                rx = 1'b0;
                k1 = cyc;
                res_ok = 1'b0;
                res_cyc = k1 + 3 + TMO;
                repeat (TMO + 10) @(posedge clk);
                #1;
                rx = 1'b1;
                check("timeout_latency", last_err_cyc - k1, 16386);
                check("timeout_ubrr", int'(UBRR), 3333);
                repeat (10) @(posedge clk);
                #1;

                // reset after the 3rd falling edge aborts silently
                arm();
                send_frame(500, 5, 1'b0);
                pulse_rst();
                check("abort_ubrr", int'(UBRR), 77);
                check("abort_busy", int'(busy), 0);
                repeat (20) @(posedge clk);
                #1;
                arm();
                send_frame(500, 10, 1'b0);
                check("ubrr_p500", int'(UBRR), 2000);

                repeat (5) @(posedge clk);
                #1;
                check("valid_pulses", n_valid, 6);
                check("err_pulses", n_err, 3);
                done = 1'b1;
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Automatic baud-rate detector for the UART, the measuring counterpart of the baud generator. When armed, it times a 0x55 sync character on the receive line (8N1, LSB first), computes the matching UBRR value as CPU_freq divided by the measured bit period, and presents it on a register output that feeds the generator's UBRR input. It sits between the RX pin synchronizer and the baud generator, and is controlled by the UART control logic.

## Interface
- CPU_freq, default 'd100000000: system clock frequency in Hz; the same value the baud generator uses.
- CNT_W, default 32: measurement counter width; sets the timeout.
- DIV_W, default 36: divider width; must satisfy 8*CPU_freq < 2^DIV_W.
- UBRR_RESET, default 12'd1: UBRR value after reset. Never 0.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idle high.
- start  in  1  one-cycle arm request.
- UBRR  out  12  detected baud value; holds its last valid result.
- ubrr_valid  out  1  one-cycle pulse when UBRR is updated.
- err  out  1  one-cycle pulse when detection fails.
- busy  out  1  high from arm until ubrr_valid or err.

## Operation
- rx passes through a 2-flop synchronizer, then an edge detector (previous-sample register). All edges see the same delay, so measured intervals are exact.
- Falling edges of 0x55 8N1 occur at bit times 0, 2, 4, 6, 8. The interval from the 1st to the 5th falling edge is exactly 8 bit periods.
- States:
  - IDLE: busy=0. When start=1, go to WAIT_START. start is ignored in every other state.
  - WAIT_START: wait indefinitely for a falling edge. On the edge, clear the counter, set edge_cnt=1, and go to MEASURE.
  - MEASURE: the counter increments every cycle.
    - On each falling edge, edge_cnt increments.
    - When edge_cnt reaches 5, latch count and go to DIVIDE.
    - If the counter reaches 2^CNT_W-1 first, pulse err and go to IDLE (timeout).
  - DIVIDE: sequential restoring divider computes q = floor(8*CPU_freq / count). It resolves one quotient bit per cycle over DIV_W cycles; the dividend is a constant of DIV_W bits.
    - If count < 8, skip the divide and pulse err.
  - DONE: one cycle.
    - If 1 ≤ q ≤ 4095: UBRR ← q[11:0] and pulse ubrr_valid.
    - Otherwise pulse err and leave UBRR unchanged.
    - Then go to IDLE.
- UBRR changes only in DONE. It is never written with 0 or with a truncated value.
- Stop-bit and rising edges are not checked.

## Timing
- Reset values: UBRR=UBRR_RESET, ubrr_valid=0, err=0, busy=0, state=IDLE, all counters 0.
- Reset in any state, including mid-MEASURE or mid-DIVIDE, aborts the operation immediately. No pulse is emitted, and UBRR returns to UBRR_RESET.
- busy rises in the cycle after start is sampled. It falls in the same cycle that ubrr_valid or err is high.
- Edge-detect latency from an rx transition to the counter event is 3 clocks.
- Latency from the 5th falling edge detection to ubrr_valid is DIV_W + 2 cycles.
- Timeout: err fires 2^CNT_W-1 cycles after the first falling edge is detected.
- ubrr_valid and err are mutually exclusive and each lasts exactly one cycle.
- A new start is accepted in the cycle after busy falls.

## Test plan
All scenarios use CPU_freq=1000000.
- Arm, then send 0x55 with a bit period of 10000 cycles -> count=80000, UBRR=100, ubrr_valid pulses once. busy returns to 0 exactly DIV_W+2 cycles after the 5th falling edge.
- Send 0x55 with a bit period of 250 cycles -> UBRR=4000. Then re-arm and send with a bit period of 2500 cycles -> UBRR=400.
- Send 0x55 with a bit period of 200 cycles -> q=5000: err pulses once, and UBRR keeps its previous value.
- Use CNT_W=20, arm, then drive rx low permanently -> err pulses 1048575 cycles after the edge detection, and the block returns to IDLE.
- Assert rst mid-MEASURE (after the 3rd falling edge) -> no ubrr_valid or err, UBRR=UBRR_RESET, busy=0. The next start plus a valid 0x55 then detects correctly.
- Pulse start while busy, and toggle rx while in IDLE -> no state change and no UBRR change.
